brick_collision_scan: RTL

//  Per-frame sweep of the brick store, sitting directly upstream of brick_memory.
//  - Drives brick_memory's address/wren.
//  - Consumes the registered health/x/y that brick_memory returns.
//  - Tests each live brick against the ball box; on overlap, pulses wren so the memory stores health-1.
//  - Reports bounce-flip flags and a live-brick count to the ball controller.

---
 rtl/brick_pkg.sv | 26 ++
 rtl/brick_collision_scan_if.sv | 33 +++
 rtl/brick_overlap.sv | 47 ++++
 rtl/brick_collision_scan.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/brick_pkg.sv
// Shared constants and FSM state encoding for the brick collision sweep.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package brick_pkg;

  localparam int NUM_BRICKS = 48;  // bricks scanned, addresses 0..NUM_BRICKS-1
  localparam int GRID_X     = 8;   // bricks per row in the playfield layout
  localparam int BRICK_W    = 40;  // brick width in pixels
  localparam int BRICK_H    = 20;  // brick height in pixels
  localparam int BALL_SZ    = 4;   // ball square side in pixels
  localparam int RD_LAT     = 2;   // address-to-data latency of brick_memory

  localparam int ADDR_W = 6;       // covers up to 64 bricks
  localparam int CNT_W  = 7;       // holds 0..64 live bricks
  localparam int WAIT_W = 2;       // counts 0..RD_LAT-1

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    CHECK,
    WRITE,
    NEXT,
    DONE
  } state_t;

endpackage

// File: rtl/brick_collision_scan_if.sv
// Bundle between the sweep, brick_memory and the ball controller.
// Latency: n/a (wires only).
// Backpressure: none; start is a pulse honoured only while the sweep is idle.
//   master: drives start/ball position and returns memory data; sees status.
//   slave : the sweep itself (brick_collision_scan).
interface brick_collision_scan_if;
  import brick_pkg::*;

  logic              start;
  logic [9:0]        ball_x;
  logic [9:0]        ball_y;
  logic [1:0]        health_in;
  logic [9:0]        brick_x_in;
  logic [9:0]        brick_y_in;
  logic [ADDR_W-1:0] address;
  logic              wren;
  logic              busy;
  logic              done;
  logic              flip_x;
  logic              flip_y;
  logic [CNT_W-1:0]  bricks_left;

  modport master (
    output start, ball_x, ball_y, health_in, brick_x_in, brick_y_in,
    input  address, wren, busy, done, flip_x, flip_y, bricks_left
  );

  modport slave (
    input  start, ball_x, ball_y, health_in, brick_x_in, brick_y_in,
    output address, wren, busy, done, flip_x, flip_y, bricks_left
  );

endinterface

// File: rtl/brick_overlap.sv
// Ball-vs-brick box test plus choice of which velocity axis to flip.
// Latency: purely combinational.
// Backpressure: none.
//   ball_x_i/ball_y_i   : ball top-left corner
//   brick_x_i/brick_y_i : brick top-left corner
//   hit_o               : boxes overlap
//   fx_o/fy_o           : flip x / flip y (only ever set together with hit_o)
module brick_overlap
  import brick_pkg::*;
(
  input  logic [9:0] ball_x_i,
  input  logic [9:0] ball_y_i,
  input  logic [9:0] brick_x_i,
  input  logic [9:0] brick_y_i,
  output logic       hit_o,
  output logic       fx_o,
  output logic       fy_o
);

  // One extra bit so right/bottom edges near 1023 do not wrap.
  logic [10:0] bl_x, bh_x, kl_x, kh_x;
  logic [10:0] bl_y, bh_y, kl_y, kh_y;
  logic [10:0] dx, dy;
  logic        ov_x, ov_y;

  assign bl_x = {1'b0, ball_x_i};
  assign bh_x = bl_x + 11'(BALL_SZ);
  assign kl_x = {1'b0, brick_x_i};
  assign kh_x = kl_x + 11'(BRICK_W);
  assign bl_y = {1'b0, ball_y_i};
  assign bh_y = bl_y + 11'(BALL_SZ);
  assign kl_y = {1'b0, brick_y_i};
  assign kh_y = kl_y + 11'(BRICK_H);

  assign ov_x = (bl_x < kh_x) && (kl_x < bh_x);
  assign ov_y = (bl_y < kh_y) && (kl_y < bh_y);

  // Penetration depth on each axis; only meaningful when the boxes overlap.
  assign dx = ((bh_x < kh_x) ? bh_x : kh_x) - ((bl_x > kl_x) ? bl_x : kl_x);
  assign dy = ((bh_y < kh_y) ? bh_y : kh_y) - ((bl_y > kl_y) ? bl_y : kl_y);

  // Shallower penetration marks the side that was struck; a tie bounces in y.
  assign hit_o = ov_x & ov_y;
  assign fx_o  = hit_o & (dx < dy);
  assign fy_o  = hit_o & ~(dx < dy);

endmodule

// File: rtl/brick_collision_scan.sv
// Per-frame sweep of brick_memory: decrements struck bricks, reports flips and live count.
// Latency: (RD_LAT+2) cycles per brick, +1 per hit, +1 for the done cycle.
// Backpressure: none; start is ignored while busy, memory reads are fixed-latency.
//   clk, resetn : clock, asynchronous active-low reset
//   bus (slave) : start/ball_x/ball_y in, memory address/wren out, health/x/y in,
//                 busy/done/flip_x/flip_y/bricks_left status out
//   Build option BRICK_SCAN_EARLY_EXIT_EN: stop the sweep after the first hit.
module brick_collision_scan
  import brick_pkg::*;
(
  input  logic                  clk,
  input  logic                  resetn,
  brick_collision_scan_if.slave bus
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [9:0]        bx_q, bx_d;
  logic [9:0]        by_q, by_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  left_q, left_d;
  logic              fx_q, fx_d;
  logic              fy_q, fy_d;

  logic hit, fx, fy;

  brick_overlap u_overlap (
    .ball_x_i  (bx_q),
    .ball_y_i  (by_q),
    .brick_x_i (bus.brick_x_in),
    .brick_y_i (bus.brick_y_in),
    .hit_o     (hit),
    .fx_o      (fx),
    .fy_o      (fy)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wait_q  <= '0;
      bx_q    <= '0;
      by_q    <= '0;
      cnt_q   <= '0;
      left_q  <= CNT_W'(NUM_BRICKS);
      fx_q    <= 1'b0;
      fy_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wait_q  <= wait_d;
      bx_q    <= bx_d;
      by_q    <= by_d;
      cnt_q   <= cnt_d;
      left_q  <= left_d;
      fx_q    <= fx_d;
      fy_q    <= fy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wait_d  = wait_q;
    bx_d    = bx_q;
    by_d    = by_q;
    cnt_d   = cnt_q;
    left_d  = left_q;
    fx_d    = fx_q;
    fy_d    = fy_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          bx_d    = bus.ball_x;
          by_d    = bus.ball_y;
          fx_d    = 1'b0;
          fy_d    = 1'b0;
          cnt_d   = '0;
          addr_d  = '0;
          wait_d  = '0;
          state_d = WAIT;
        end
      end

      // Hold the address until brick_memory's registered output catches up.
      WAIT: begin
        if (wait_q == WAIT_W'(RD_LAT - 1)) begin
          state_d = CHECK;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end

      CHECK: begin
        if (bus.health_in == 2'd0) begin
          state_d = NEXT;
        end else if (!hit) begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = NEXT;
        end else begin
          // A brick on its last point dies on this hit and is not counted.
          if (bus.health_in > 2'd1) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
          state_d = WRITE;
        end
      end

      // Address and read data are still those of the struck brick here.
      WRITE: begin
        fx_d = fx_q | fx;
        fy_d = fy_q | fy;
`ifdef BRICK_SCAN_EARLY_EXIT_EN
        // Partial sweep: the running count is meaningless, so derive the
        // result from the previous total; DONE then copies it out as usual.
        cnt_d   = left_q - CNT_W'(bus.health_in == 2'd1);
        state_d = DONE;
`else
        state_d = NEXT;
`endif
      end

      NEXT: begin
        if (addr_q == ADDR_W'(NUM_BRICKS - 1)) begin
          state_d = DONE;
        end else begin
          addr_d  = addr_q + ADDR_W'(1);
          wait_d  = '0;
          state_d = WAIT;
        end
      end

      DONE: begin
        left_d  = cnt_q;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.address     = addr_q;
  assign bus.wren        = (state_q == WRITE);
  assign bus.busy        = (state_q != IDLE);
  assign bus.done        = (state_q == DONE);
  assign bus.flip_x      = fx_q;
  assign bus.flip_y      = fy_q;
  assign bus.bricks_left = left_q;

endmodule
